// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
// Shared types and constants for the SRAM arbiter: FSM state encoding, access owner encoding,
// default SRAM address/data widths, starvation counter width and the winner-selection rule.
// No ports (package).

package sram_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W  = 16;
    localparam int unsigned ARB_DATA_W  = 16;
    localparam int unsigned STARVE_W    = 4;

    typedef enum logic [1:0] {
        ArbIdle   = 2'd0,
        ArbAccess = 2'd1,
        ArbTurn   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnCpu = 1'b0,
        OwnVga = 1'b1
    } owner_e;

    // CPU wins when it is the only requester, or when it has waited long enough.
    function automatic logic cpu_wins(input logic cpu_req, input logic vga_req,
                                      input logic starved);
        return cpu_req && (!vga_req || starved);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Bundles the CPU request path, the VGA fetch path and the SRAM macro pins.
//   slave  : arbiter view (takes requests, drives grants, read data and SRAM pins)
//   master : requester/SRAM view (drives requests and SRAM read data, observes the rest)
// Parameters: ADDR_W (word address width), DATA_W (data width).

interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);

    // CPU load/store path
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // VGA frame-buffer fetch (read-only)
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    // SRAM macro pins
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  vga_req, vga_addr,
        output vga_gnt, vga_rvalid, vga_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output vga_req, vga_addr,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/sram_arbiter_starve_ctr.sv
// sram_arbiter_starve_ctr
// Saturating CPU starvation counter with increment and clear.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   inc        : count one more CPU loss (saturates at STARVE_MAX)
//   clr        : clear to zero (has priority over inc)
//   cnt        : current count
//   at_max     : cnt has reached STARVE_MAX

module sram_arbiter_starve_ctr
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_max
);

    localparam logic [STARVE_W-1:0] MaxCnt = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MaxCnt)) begin
            cnt_q <= cnt_q + STARVE_W'(1);
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MaxCnt);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one single-port synchronous SRAM between the CPU load/store path and the VGA fetch.
// VGA has fixed priority; a CPU that has lost STARVE_MAX consecutive arbitrations wins the next.
// Ports:
//   clk, rst : clock, synchronous active-low reset
//   bus      : sram_arbiter_if.slave (CPU req/gnt/rvalid, VGA req/gnt/rvalid, SRAM pins)
// Sequencing: IDLE samples requests, ACCESS drives the SRAM and pulses the owner's gnt,
// a read returns rvalid the cycle after ACCESS, a write is followed by one TURN bubble.

module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned DATA_W     = ARB_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    sram_arbiter_if.slave bus
);

    arb_state_e          state_q;
    owner_e              owner_q;
    logic                cpu_gnt_q;
    logic                vga_gnt_q;
    logic                cpu_rvalid_q;
    logic                vga_rvalid_q;
    logic                sram_en_q;
    logic                sram_we_q;
    logic [ADDR_W-1:0]   sram_addr_q;
    logic [DATA_W-1:0]   sram_wdata_q;

    logic [STARVE_W-1:0] starve_cnt;
    logic                starved;
    logic                in_idle;
    logic                any_req;
    logic                cpu_win;
    logic                starve_inc;
    logic                starve_clr;

    assign in_idle = (state_q == ArbIdle);
    assign any_req = bus.cpu_req || bus.vga_req;
    assign cpu_win = cpu_wins(bus.cpu_req, bus.vga_req, starved);

    // Count only IDLE cycles where the CPU asked and lost; any CPU win or idle CPU clears.
    assign starve_inc = in_idle && bus.cpu_req && !cpu_win;
    assign starve_clr = !bus.cpu_req || (in_idle && cpu_win);

    sram_arbiter_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .cnt    (starve_cnt),
        .at_max (starved)
    );

    // All bus-facing outputs are registered here, so there is no req-to-gnt combinational path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ArbIdle;
            owner_q      <= OwnCpu;
            cpu_gnt_q    <= 1'b0;
            vga_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vga_rvalid_q <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            // Pulsed outputs default low; only the transitions below raise them.
            cpu_gnt_q    <= 1'b0;
            vga_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vga_rvalid_q <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;

            unique case (state_q)
                ArbIdle: begin
                    if (any_req) begin
                        owner_q      <= cpu_win ? OwnCpu : OwnVga;
                        sram_en_q    <= 1'b1;
                        sram_we_q    <= cpu_win && bus.cpu_we;
                        sram_addr_q  <= cpu_win ? bus.cpu_addr : bus.vga_addr;
                        sram_wdata_q <= cpu_win ? bus.cpu_wdata : '0;
                        cpu_gnt_q    <= cpu_win;
                        vga_gnt_q    <= !cpu_win;
                        state_q      <= ArbAccess;
                    end
                end
                ArbAccess: begin
                    // sram_we_q still holds this access's direction during ACCESS.
                    if (sram_we_q) begin
                        state_q <= ArbTurn;
                    end else begin
                        cpu_rvalid_q <= (owner_q == OwnCpu);
                        vga_rvalid_q <= (owner_q == OwnVga);
                        state_q      <= ArbIdle;
                    end
                end
                ArbTurn: begin
                    state_q <= ArbIdle;
                end
                default: begin
                    state_q <= ArbIdle;
                end
            endcase
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.vga_gnt    = vga_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.vga_rvalid = vga_rvalid_q;
    assign bus.sram_en    = sram_en_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;

    // Read data is only qualified by the matching rvalid.
    assign bus.cpu_rdata  = bus.sram_rdata;
    assign bus.vga_rdata  = bus.sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Directed self-checking bench for sram_arbiter, with a small synchronous SRAM model.

module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [15:0] mem [0:1023];

    sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    sram_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous SRAM: read data appears the cycle after a read access.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr[9:0]] <= bus.sram_wdata;
            else             bus.sram_rdata <= mem[bus.sram_addr[9:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.vga_gnt !== 1'b0) begin
            errors++; $display("FAIL rst_gnt: got %b%b want 00", bus.cpu_gnt, bus.vga_gnt);
        end
        checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.vga_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_rvalid: got %b%b want 00", bus.cpu_rvalid, bus.vga_rvalid);
        end
        checks++;
        if (bus.sram_en !== 1'b0 || bus.sram_we !== 1'b0) begin
            errors++; $display("FAIL rst_en_we: got %b%b want 00", bus.sram_en, bus.sram_we);
        end
        checks++;
        if (bus.sram_addr !== 16'h0 || bus.sram_wdata !== 16'h0) begin
            errors++;
            $display("FAIL rst_addr_wdata: got %h %h want 0000 0000", bus.sram_addr, bus.sram_wdata);
        end
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
            errors++; $display("FAIL rst_starve: got %0d want 0", dut.starve_cnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.sram_en !== 1'b0) begin
            errors++; $display("FAIL rst_idle_no_req: got en %b want 0", bus.sram_en);
        end
    endtask

    task automatic test_cpu_read();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        tick();
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.vga_gnt !== 1'b0) begin
            errors++; $display("FAIL rd_gnt: got cpu %b vga %b want 1 0", bus.cpu_gnt, bus.vga_gnt);
        end
        checks++;
        if (bus.sram_en !== 1'b1 || bus.sram_we !== 1'b0 || bus.sram_addr !== 16'h0010) begin
            errors++;
            $display("FAIL rd_access: got en %b we %b addr %h want 1 0 0010",
                     bus.sram_en, bus.sram_we, bus.sram_addr);
        end
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_rvalid: got %b %h want 1 beef", bus.cpu_rvalid, bus.cpu_rdata);
        end
        checks++;
        if (bus.vga_rvalid !== 1'b0 || bus.sram_en !== 1'b0 || bus.cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rd_after: got vrv %b en %b gnt %b want 0 0 0",
                     bus.vga_rvalid, bus.sram_en, bus.cpu_gnt);
        end
        tick();
        checks++;
        if (bus.cpu_rvalid !== 1'b0) begin
            errors++; $display("FAIL rd_rvalid_pulse: got %b want 0", bus.cpu_rvalid);
        end
    endtask

    task automatic test_cpu_write();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'h1234;
        tick();
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.sram_en !== 1'b1 || bus.sram_we !== 1'b1) begin
            errors++;
            $display("FAIL wr_access: got gnt %b en %b we %b want 1 1 1",
                     bus.cpu_gnt, bus.sram_en, bus.sram_we);
        end
        checks++;
        if (bus.sram_addr !== 16'h0020 || bus.sram_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL wr_addr_data: got %h %h want 0020 1234", bus.sram_addr, bus.sram_wdata);
        end
        // Immediately request a read-back of the same word.
        bus.cpu_we = 1'b0; bus.cpu_wdata = 16'h0;
        tick();
        checks++;
        if (bus.sram_en !== 1'b0 || bus.cpu_gnt !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_turn: got en %b gnt %b rvalid %b want 0 0 0",
                     bus.sram_en, bus.cpu_gnt, bus.cpu_rvalid);
        end
        checks++;
        if (dut.state_q !== ArbTurn) begin
            errors++; $display("FAIL wr_turn_state: got %0d want %0d", dut.state_q, ArbTurn);
        end
        tick();
        checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.sram_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_early_gnt: got gnt %b rvalid %b en %b want 0 0 0",
                     bus.cpu_gnt, bus.cpu_rvalid, bus.sram_en);
        end
        tick();
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.sram_we !== 1'b0 || bus.sram_addr !== 16'h0020) begin
            errors++;
            $display("FAIL wr_next_gnt: got gnt %b we %b addr %h want 1 0 0020",
                     bus.cpu_gnt, bus.sram_we, bus.sram_addr);
        end
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL wr_readback: got %b %h want 1 1234", bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0100;
        tick();
        checks++;
        if (bus.vga_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 || bus.sram_addr !== 16'h0100) begin
            errors++;
            $display("FAIL sim_vga_first: got vga %b cpu %b addr %h want 1 0 0100",
                     bus.vga_gnt, bus.cpu_gnt, bus.sram_addr);
        end
        checks++;
        if (dut.starve_cnt !== 4'd1) begin
            errors++; $display("FAIL sim_starve_inc: got %0d want 1", dut.starve_cnt);
        end
        bus.vga_req = 1'b0;
        tick();
        checks++;
        if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 16'hA5A5 || bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL sim_vga_rvalid: got %b %h cpu_rv %b want 1 a5a5 0",
                     bus.vga_rvalid, bus.vga_rdata, bus.cpu_rvalid);
        end
        tick();
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.vga_gnt !== 1'b0 || bus.sram_addr !== 16'h0010) begin
            errors++;
            $display("FAIL sim_cpu_next: got cpu %b vga %b addr %h want 1 0 0010",
                     bus.cpu_gnt, bus.vga_gnt, bus.sram_addr);
        end
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'hBEEF || bus.vga_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL sim_cpu_rvalid: got %b %h vga_rv %b want 1 beef 0",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.vga_rvalid);
        end
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
            errors++; $display("FAIL sim_starve_clr: got %0d want 0", dut.starve_cnt);
        end
    endtask

    task automatic test_starvation();
        int  vga_gnts;
        bit  cpu_seen;
        vga_gnts = 0;
        cpu_seen = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0101;
        for (int cyc = 0; cyc < 40 && !cpu_seen; cyc++) begin
            tick();
            if (bus.vga_gnt === 1'b1) vga_gnts++;
            if (bus.cpu_gnt === 1'b1) begin
                cpu_seen = 1'b1;
                checks++;
                if (bus.vga_gnt !== 1'b0 || bus.sram_addr !== 16'h0010) begin
                    errors++;
                    $display("FAIL stv_cpu_access: got vga %b addr %h want 0 0010",
                             bus.vga_gnt, bus.sram_addr);
                end
                checks++;
                if (dut.starve_cnt !== 4'd0) begin
                    errors++; $display("FAIL stv_starve_clr: got %0d want 0", dut.starve_cnt);
                end
                bus.cpu_req = 1'b0;
                bus.vga_req = 1'b0;
            end
        end
        checks++;
        if (!cpu_seen) begin
            errors++; $display("FAIL stv_cpu_timeout: got no cpu_gnt in 40 cycles want one");
        end
        checks++;
        if (vga_gnts != 4) begin
            errors++; $display("FAIL stv_vga_count: got %0d want 4", vga_gnts);
        end
        tick();
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL stv_cpu_rvalid: got %b %h want 1 beef", bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0100;
        tick();
        checks++;
        if (bus.vga_gnt !== 1'b1 || bus.sram_addr !== 16'h0100) begin
            errors++;
            $display("FAIL b2b_gnt0: got %b %h want 1 0100", bus.vga_gnt, bus.sram_addr);
        end
        bus.vga_addr = 16'h0101;
        tick();
        checks++;
        if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 16'hA5A5 || bus.vga_gnt !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rv0: got rv %b %h gnt %b want 1 a5a5 0",
                     bus.vga_rvalid, bus.vga_rdata, bus.vga_gnt);
        end
        tick();
        checks++;
        if (bus.vga_gnt !== 1'b1 || bus.sram_addr !== 16'h0101 || bus.vga_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gnt1: got gnt %b addr %h rv %b want 1 0101 0",
                     bus.vga_gnt, bus.sram_addr, bus.vga_rvalid);
        end
        bus.vga_req = 1'b0;
        tick();
        checks++;
        if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 16'h5A5A || bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rv1: got rv %b %h cpu_rv %b want 1 5a5a 0",
                     bus.vga_rvalid, bus.vga_rdata, bus.cpu_rvalid);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        tick();
        checks++;
        if (bus.cpu_gnt !== 1'b1 || dut.state_q !== ArbAccess) begin
            errors++;
            $display("FAIL rmr_in_access: got gnt %b state %0d want 1 %0d",
                     bus.cpu_gnt, dut.state_q, ArbAccess);
        end
        bus.cpu_req = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.vga_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rmr_pulses: got gnt %b crv %b vrv %b want 0 0 0",
                     bus.cpu_gnt, bus.cpu_rvalid, bus.vga_rvalid);
        end
        checks++;
        if (bus.sram_en !== 1'b0 || bus.sram_we !== 1'b0 || bus.sram_addr !== 16'h0 ||
            bus.sram_wdata !== 16'h0) begin
            errors++;
            $display("FAIL rmr_sram: got en %b we %b addr %h wd %h want 0 0 0000 0000",
                     bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata);
        end
        checks++;
        if (dut.state_q !== ArbIdle) begin
            errors++; $display("FAIL rmr_state: got %0d want %0d", dut.state_q, ArbIdle);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rmr_no_late_rvalid: got rv %b gnt %b want 0 0",
                     bus.cpu_rvalid, bus.cpu_gnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[10'h010] = 16'hBEEF;
        mem[10'h100] = 16'hA5A5;
        mem[10'h101] = 16'h5A5A;
        rst           = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0;
        bus.cpu_wdata = 16'h0;
        bus.vga_req   = 1'b0;
        bus.vga_addr  = 16'h0;
        bus.sram_rdata = 16'h0;

        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer for the single-port synchronous data SRAM. It shares the SRAM between the CPU load/store path (controller LOAD0/LOAD1/STORE states, SRAM_BUF/SRAM_MUX datapath) and the VGA frame-buffer fetch. VGA gets fixed priority, and a bounded-wait guard prevents CPU starvation. The block sits between the CPU datapath, the VGA fetch unit and the SRAM macro pins.

## Interface
Parameters:
- ADDR_W, 16, SRAM word-address width
- DATA_W, 16, data width (matches `DATAWIDTH`)
- STARVE_MAX, 4, CPU wait cycles after which CPU beats VGA (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted (1-cycle pulse)
- cpu_rvalid  out  1  CPU read data valid (1-cycle pulse)
- cpu_rdata  out  DATA_W  CPU read data
- vga_req  in  1  VGA read request (read-only)
- vga_addr  in  ADDR_W  VGA word address
- vga_gnt  out  1  VGA access accepted (1-cycle pulse)
- vga_rvalid  out  1  VGA read data valid (1-cycle pulse)
- vga_rdata  out  DATA_W  VGA read data
- sram_en, sram_we  out  1  SRAM chip enable, write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read access

## Operation
- FSM states: IDLE, ACCESS, TURN.
- IDLE:
  - Sample requests.
  - If vga_req or cpu_req is high, choose a winner and register owner, we, addr and wdata (wdata = 0 for VGA).
  - Next state is ACCESS. With no request, stay in IDLE.
- Winner rule:
  - Only one requester: that requester wins.
  - Both requesters: VGA wins, unless starve_cnt == STARVE_MAX, in which case CPU wins.
- ACCESS:
  - sram_en = 1, sram_we = registered we, sram_addr/sram_wdata = registered values.
  - The owner's gnt = 1.
  - Next state is TURN if the access is a write, otherwise IDLE.
- TURN: one bus-turnaround bubble, sram_en = 0, then IDLE.
- Read return:
  - The owner's rvalid pulses in the cycle after ACCESS.
  - cpu_rdata and vga_rdata both pass through sram_rdata combinationally and are meaningful only while the matching rvalid is high.
  - Writes produce no rvalid.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, in each IDLE cycle where cpu_req = 1 and VGA wins.
  - Clears when CPU is granted or cpu_req = 0.
- Requester rules:
  - Hold req, addr, we and wdata stable from req assertion until gnt.
  - Drive req low in the cycle after gnt, unless a new access is intended.
  - Requests are not sampled in ACCESS or TURN.
- Reset (rst = 0 at a clock edge, in any state):
  - State goes to IDLE, starve_cnt = 0.
  - All outputs are 0: gnt, rvalid, sram_en, sram_we, sram_addr, sram_wdata.
  - An in-flight read is dropped; no rvalid follows reset.

## Timing
- Grant latency: req high in IDLE at cycle N gives gnt and the SRAM access in N+1, and rvalid in N+2.
- Read throughput is one access per 2 cycles. Back-to-back reads are possible because IDLE (N+2) overlaps rvalid.
- A write occupies 3 cycles: IDLE, ACCESS, TURN.
- Worst-case CPU wait under continuous VGA traffic: STARVE_MAX VGA accesses, then CPU is granted.
- gnt, rvalid and all sram_* outputs are registered or derived from state only; there is no combinational req-to-gnt path.

## Structure
- Put in shared defines/package (defines.v): state encodings (`ARB_IDLE`, `ARB_ACCESS`, `ARB_TURN`), owner encoding (`OWN_CPU`, `OWN_VGA`), and SRAM address width.
- The CPU controller drives cpu_req/cpu_we from its LOAD0/STORE states.
- No sub-module is required. The starvation guard may be factored as `arb_starve_ctr` (saturating counter with inc/clr).

## Test plan
- Reset mid-read: reset asserted in ACCESS of a CPU read -> next cycle all outputs 0, no cpu_rvalid, state IDLE.
- CPU read alone: cpu_req with addr 0x0010 at N, SRAM returns 0xBEEF -> cpu_gnt at N+1 with sram_addr = 0x0010, cpu_rvalid at N+2 with cpu_rdata = 0xBEEF.
- CPU write: addr 0x0020, wdata 0x1234 -> sram_we = 1 in ACCESS, TURN bubble with sram_en = 0, no rvalid, next grant no earlier than 3 cycles after request.
- Simultaneous requests at N -> vga_gnt at N+1. CPU is granted after the VGA read, or earlier if starve_cnt has reached STARVE_MAX.
- VGA continuously requesting, CPU holding a read, STARVE_MAX = 4 -> exactly 4 vga_gnt pulses, then cpu_gnt. starve_cnt is 0 after the CPU grant.
- Back-to-back VGA reads at addresses 0x100, 0x101 -> vga_gnt every 2 cycles, each vga_rvalid one cycle after its vga_gnt.
